rom_ctrl_readout_seq: RTL

// Sits directly upstream of the scrambled ROM. Walks the whole ROM once after start_i by issuing

---
 rtl/rom_ctrl_readout_seq.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rom_ctrl_readout_seq.sv
// Readout sequencer for the scrambled ROM: walks every word once, streams the low words to the
// hash engine and captures the top words as the expected digest.
// Optional ROM_CTRL_READOUT_ADDR_CHECK_EN adds an independent keystream address counter plus compare.
module rom_ctrl_readout_seq #(
  parameter int Depth       = 16,
  parameter int Width       = 40,
  parameter int DataW       = 32,
  parameter int DigestWords = 8,
  parameter int FifoDepth   = 2,
  localparam int Aw         = $clog2(Depth)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  output logic                         rom_req_o,
  output logic [Aw-1:0]                rom_addr_o,
  output logic [Aw-1:0]                prince_addr_o,
  input  logic                         rom_rvalid_i,
  input  logic [Width-1:0]             rom_clr_rdata_i,
  output logic                         data_valid_o,
  output logic [DataW-1:0]             data_o,
  output logic                         data_last_o,
  input  logic                         data_ready_i,
  output logic [DigestWords*DataW-1:0] digest_o,
  output logic                         done_o,
  output logic                         alert_o
);

  localparam int DigestBase = Depth - DigestWords;
  localparam int PtrW       = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW       = $clog2(FifoDepth + 1);
  localparam logic [Aw-1:0] LastAddr       = Aw'(Depth - 1);
  localparam logic [Aw-1:0] DigestAddr     = Aw'(DigestBase);
  localparam logic [Aw-1:0] LastStreamAddr = Aw'(DigestBase - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StDrain = 3'd2,
    StDone  = 3'd3,
    StError = 3'd4
  } state_e;

  state_e                         state_r, state_next_s;
  logic [Aw-1:0]                  addr_r;
  logic [Aw-1:0]                  resp_addr_r;
  logic                           outstanding_r;
  logic                           alert_r;
  logic [DataW-1:0]               fifo_data_r [FifoDepth];
  logic                           fifo_last_r [FifoDepth];
  logic [PtrW-1:0]                rd_ptr_r, wr_ptr_r;
  logic [CntW-1:0]                count_r;
  logic [DigestWords*DataW-1:0]   digest_r;

  logic            req_s, push_s, push_ok_s, pop_s, digest_we_s;
  logic            valid_s, full_s, stream_out_s, mismatch_s, alert_set_s;
  logic [CntW:0]   inflight_s;
  logic            unused_ecc_s;

  // ECC bits are checked elsewhere; only the data bits travel on.
  assign unused_ecc_s = ^rom_clr_rdata_i[Width-1:DataW];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FifoDepth - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

`ifdef ROM_CTRL_READOUT_ADDR_CHECK_EN
  logic [Aw-1:0] prince_addr_r;

  // Shadow keystream counter, advanced by the same request strobe as the ROM counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prince_addr_r <= {Aw{1'b0}};
    end else if (req_s && (prince_addr_r != LastAddr)) begin
      prince_addr_r <= prince_addr_r + Aw'(1);
    end else begin
      prince_addr_r <= prince_addr_r;
    end
  end

  assign prince_addr_o = prince_addr_r;
`else
  assign prince_addr_o = addr_r;
`endif

  // Request throttling, response routing, alert detection and next state.
  always_comb begin
    state_next_s = state_r;
    req_s        = 1'b0;
    push_s       = 1'b0;
    digest_we_s  = 1'b0;
    mismatch_s   = 1'b0;
    valid_s      = (count_r != {CntW{1'b0}}) && !alert_r;
    pop_s        = valid_s && data_ready_i;
    full_s       = (count_r == CntW'(FifoDepth));
    stream_out_s = outstanding_r && (resp_addr_r < DigestAddr);
    inflight_s   = {1'b0, count_r} + {{CntW{1'b0}}, stream_out_s};

    if (rom_rvalid_i && outstanding_r && !alert_r) begin
      if (resp_addr_r < DigestAddr) begin
        push_s = 1'b1;
      end else begin
        digest_we_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
    push_ok_s = push_s && (!full_s || pop_s);

    // Digest words bypass the FIFO, so only stream-bound reads are throttled.
    if ((state_r == StRead) && !rst_i) begin
      req_s = (addr_r >= DigestAddr) || (inflight_s < (CntW+1)'(FifoDepth));
    end else begin
      req_s = 1'b0;
    end

`ifdef ROM_CTRL_READOUT_ADDR_CHECK_EN
    if (state_r == StRead) begin
      mismatch_s = (addr_r != prince_addr_r);
    end else begin
      mismatch_s = 1'b0;
    end
`endif

    alert_set_s = (rom_rvalid_i && !outstanding_r) ||
                  (outstanding_r && !rom_rvalid_i) ||
                  (push_s && full_s && !pop_s) ||
                  mismatch_s;

    if (alert_set_s || alert_r) begin
      state_next_s = StError;
    end else begin
      case (state_r)
        StIdle:  state_next_s = start_i ? StRead : StIdle;
        StRead:  state_next_s = (req_s && (addr_r == LastAddr)) ? StDrain : StRead;
        StDrain: state_next_s = (!outstanding_r && (count_r == {CntW{1'b0}})) ? StDone : StDrain;
        StDone:  state_next_s = StDone;
        StError: state_next_s = StError;
        default: state_next_s = StError;
      endcase
    end
  end

  // State, address counter, response tracking and sticky alert.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= StIdle;
      addr_r        <= {Aw{1'b0}};
      resp_addr_r   <= {Aw{1'b0}};
      outstanding_r <= 1'b0;
      alert_r       <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      outstanding_r <= req_s;
      alert_r       <= alert_r | alert_set_s;
      if (req_s) begin
        resp_addr_r <= addr_r;
        addr_r      <= (addr_r == LastAddr) ? addr_r : addr_r + Aw'(1);
      end else begin
        resp_addr_r <= resp_addr_r;
        addr_r      <= addr_r;
      end
    end
  end

  // Stream FIFO; cleared on reset so no stale word is visible afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_r <= {PtrW{1'b0}};
      wr_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_data_r[i] <= {DataW{1'b0}};
        fifo_last_r[i] <= 1'b0;
      end
    end else begin
      if (push_ok_s) begin
        fifo_data_r[wr_ptr_r] <= rom_clr_rdata_i[DataW-1:0];
        fifo_last_r[wr_ptr_r] <= (resp_addr_r == LastStreamAddr);
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Digest capture; frozen once an alert is raised.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digest_r <= {(DigestWords*DataW){1'b0}};
    end else begin
      for (int k = 0; k < DigestWords; k++) begin
        if (digest_we_s && (resp_addr_r == Aw'(DigestBase + k))) begin
          digest_r[k*DataW +: DataW] <= rom_clr_rdata_i[DataW-1:0];
        end else begin
          digest_r[k*DataW +: DataW] <= digest_r[k*DataW +: DataW];
        end
      end
    end
  end

  assign rom_req_o    = req_s;
  assign rom_addr_o   = addr_r;
  assign data_valid_o = valid_s;
  assign data_o       = fifo_data_r[rd_ptr_r];
  assign data_last_o  = valid_s && fifo_last_r[rd_ptr_r];
  assign digest_o     = digest_r;
  assign done_o       = (state_r == StDone);
  assign alert_o      = alert_r;

endmodule
